// File: rtl/prog_loader.sv
// Byte-stream program loader: frames length/data/checksum bytes into 32-bit
// instruction words, writes them to program memory and holds the core until done.
module prog_loader #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  input  logic        reload,
  output logic        progWrite,
  output logic [31:0] progAddr,
  output logic [31:0] progData,
  output logic        coreHold,
  output logic        loadDone,
  output logic        loadError
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] LP_DEPTH = 17'(DEPTH_WORDS);

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_len;
  logic [15:0] r_wordIdx;
  logic [1:0]  r_lane;
  logic [23:0] r_shift;
  logic [7:0]  r_csum;
  logic        r_progWrite;
  logic [31:0] r_progAddr;
  logic [31:0] r_progData;
  logic        w_accept;
  logic        w_lastWord;
  logic [15:0] w_lenFull;

  assign w_accept   = byteValid && byteReady;
  assign w_lenFull  = {byteIn, r_len[7:0]};
  assign w_lastWord = (r_lane == 2'd3) && (r_wordIdx == (r_len - 16'd1));

  assign progWrite  = r_progWrite;
  assign progAddr   = r_progAddr;
  assign progData   = r_progData;

  always_comb begin
    byteReady = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                (r_state == S_DATA)   || (r_state == S_CSUM);
    coreHold  = (r_state != S_DONE);
    loadDone  = (r_state == S_DONE);
    loadError = (r_state == S_ERROR);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_LEN_LO;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_LEN_LO: if (w_accept) w_nextState = S_LEN_HI;
      S_LEN_HI: begin
        if (w_accept) begin
          if ({1'b0, w_lenFull} > LP_DEPTH) w_nextState = S_ERROR;
          else if (w_lenFull == 16'd0)       w_nextState = S_CSUM;
          else                               w_nextState = S_DATA;
        end
      end
      S_DATA:   if (w_accept && w_lastWord) w_nextState = S_CSUM;
      S_CSUM: begin
        if (w_accept) w_nextState = (byteIn == r_csum) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: if (reload) w_nextState = S_LEN_LO;
      default: w_nextState = S_LEN_LO;
    endcase
  end

  // Checksum covers every accepted byte except the checksum byte itself;
  // the write strobe is registered so it lands the cycle after lane 3.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_len       <= '0;
      r_wordIdx   <= '0;
      r_lane      <= '0;
      r_shift     <= '0;
      r_csum      <= '0;
      r_progWrite <= 1'b0;
      r_progAddr  <= '0;
      r_progData  <= '0;
    end else begin
      r_progWrite <= 1'b0;
      if (w_accept && (r_state != S_CSUM)) r_csum <= r_csum + byteIn;
      case (r_state)
        S_LEN_LO: if (w_accept) r_len[7:0] <= byteIn;
        S_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= byteIn;
            r_lane      <= '0;
            r_wordIdx   <= '0;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_lane <= r_lane + 2'd1;
            case (r_lane)
              2'd0: r_shift[7:0]   <= byteIn;
              2'd1: r_shift[15:8]  <= byteIn;
              2'd2: r_shift[23:16] <= byteIn;
              default: begin
                r_progWrite <= 1'b1;
                r_progData  <= {byteIn, r_shift};
                r_progAddr  <= {14'd0, r_wordIdx, 2'b00};
                r_wordIdx   <= r_wordIdx + 16'd1;
              end
            endcase
          end
        end
        S_DONE, S_ERROR: begin
          if (reload) begin
            r_csum    <= '0;
            r_lane    <= '0;
            r_wordIdx <= '0;
            r_len     <= '0;
            r_shift   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: framing, checksum, length
// limits, mid-load reset, gapped streams and reload.
module tb_prog_loader;

  logic        Clock;
  logic        nReset;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        reload;
  logic        progWrite;
  logic [31:0] progAddr;
  logic [31:0] progData;
  logic        coreHold;
  logic        loadDone;
  logic        loadError;

  int          compCnt;
  int          failCnt;
  int          wrCnt;
  logic [31:0] wrAddr [0:7];
  logic [31:0] wrData [0:7];
  logic [7:0]  stream [$];

  prog_loader #(.DEPTH_WORDS(256)) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .byteIn    (byteIn),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .reload    (reload),
    .progWrite (progWrite),
    .progAddr  (progAddr),
    .progData  (progData),
    .coreHold  (coreHold),
    .loadDone  (loadDone),
    .loadError (loadError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Capture every write strobe shortly after the rising edge
  always begin
    @(posedge Clock);
    #2;
    if (progWrite === 1'b1) begin
      if (wrCnt < 8) begin
        wrAddr[wrCnt] = progAddr;
        wrData[wrCnt] = progData;
      end
      wrCnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        byteValid = 1'b0;
        byteIn    = 8'hFF;
        @(negedge Clock);
      end
    end
    byteIn    = b;
    byteValid = 1'b1;
    checkOutput("byteReady_while_streaming", {31'd0, byteReady}, 32'd1);
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic sendStream(input bit gaps);
    foreach (stream[i]) applyStimulus(stream[i], gaps);
    byteValid = 1'b0;
    byteIn    = 8'hFF;
  endtask

  task automatic doReload();
    reload = 1'b1;
    @(negedge Clock);
    reload = 1'b0;
    checkOutput("reload_coreHold", {31'd0, coreHold}, 32'd1);
    checkOutput("reload_loadDone", {31'd0, loadDone}, 32'd0);
    checkOutput("reload_loadError", {31'd0, loadError}, 32'd0);
    checkOutput("reload_byteReady", {31'd0, byteReady}, 32'd1);
    wrCnt = 0;
  endtask

  initial begin
    compCnt   = 0;
    failCnt   = 0;
    wrCnt     = 0;
    nReset    = 1'b0;
    byteIn    = 8'h00;
    byteValid = 1'b0;
    reload    = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    checkOutput("rst_progWrite", {31'd0, progWrite}, 32'd0);
    checkOutput("rst_progAddr", progAddr, 32'd0);
    checkOutput("rst_progData", progData, 32'd0);
    checkOutput("rst_coreHold", {31'd0, coreHold}, 32'd1);
    checkOutput("rst_loadDone", {31'd0, loadDone}, 32'd0);
    checkOutput("rst_loadError", {31'd0, loadError}, 32'd0);
    nReset = 1'b1;
    @(negedge Clock);
    checkOutput("rst_byteReady", {31'd0, byteReady}, 32'd1);

    $display("[TB] single-word load");
    stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
    sendStream(1'b0);
    checkOutput("w1_count", wrCnt, 32'd1);
    checkOutput("w1_addr", wrAddr[0], 32'h0000_0000);
    checkOutput("w1_data", wrData[0], 32'h0000_0013);
    checkOutput("w1_loadDone", {31'd0, loadDone}, 32'd1);
    checkOutput("w1_coreHold", {31'd0, coreHold}, 32'd0);
    checkOutput("w1_byteReady", {31'd0, byteReady}, 32'd0);
    doReload();

    $display("[TB] two-word back-to-back load");
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'h10, 8'h00, 8'h09};
    sendStream(1'b0);
    checkOutput("w2_count", wrCnt, 32'd2);
    checkOutput("w2_addr0", wrAddr[0], 32'h0000_0000);
    checkOutput("w2_data0", wrData[0], 32'h0050_0093);
    checkOutput("w2_addr1", wrAddr[1], 32'h0000_0004);
    checkOutput("w2_data1", wrData[1], 32'h0010_0113);
    checkOutput("w2_loadDone", {31'd0, loadDone}, 32'd1);
    doReload();

    $display("[TB] zero-length loads");
    stream = '{8'h00, 8'h00, 8'h00};
    sendStream(1'b0);
    checkOutput("z_count", wrCnt, 32'd0);
    checkOutput("z_loadDone", {31'd0, loadDone}, 32'd1);
    checkOutput("z_loadError", {31'd0, loadError}, 32'd0);
    doReload();
    stream = '{8'h00, 8'h00, 8'h05};
    sendStream(1'b0);
    checkOutput("zbad_loadError", {31'd0, loadError}, 32'd1);
    checkOutput("zbad_loadDone", {31'd0, loadDone}, 32'd0);
    checkOutput("zbad_coreHold", {31'd0, coreHold}, 32'd1);
    checkOutput("zbad_byteReady", {31'd0, byteReady}, 32'd0);
    doReload();

    $display("[TB] oversize length");
    stream = '{8'h01, 8'h01};
    sendStream(1'b0);
    checkOutput("big_loadError", {31'd0, loadError}, 32'd1);
    checkOutput("big_byteReady", {31'd0, byteReady}, 32'd0);
    checkOutput("big_coreHold", {31'd0, coreHold}, 32'd1);
    checkOutput("big_count", wrCnt, 32'd0);
    doReload();

    $display("[TB] reset during word 1");
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10};
    sendStream(1'b0);
    checkOutput("mid_count_before", wrCnt, 32'd1);
    nReset = 1'b0;
    #2;
    checkOutput("mid_progWrite", {31'd0, progWrite}, 32'd0);
    checkOutput("mid_progAddr", progAddr, 32'd0);
    checkOutput("mid_progData", progData, 32'd0);
    checkOutput("mid_coreHold", {31'd0, coreHold}, 32'd1);
    checkOutput("mid_loadDone", {31'd0, loadDone}, 32'd0);
    checkOutput("mid_loadError", {31'd0, loadError}, 32'd0);
    @(negedge Clock);
    nReset = 1'b1;
    wrCnt  = 0;
    @(negedge Clock);
    checkOutput("mid_byteReady", {31'd0, byteReady}, 32'd1);
    checkOutput("mid_idle_count", wrCnt, 32'd0);
    stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
    sendStream(1'b0);
    checkOutput("mid_fresh_count", wrCnt, 32'd1);
    checkOutput("mid_fresh_addr", wrAddr[0], 32'h0000_0000);
    checkOutput("mid_fresh_data", wrData[0], 32'h0000_0013);
    checkOutput("mid_fresh_done", {31'd0, loadDone}, 32'd1);
    doReload();

    $display("[TB] gapped two-word load");
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'h10, 8'h00, 8'h09};
    sendStream(1'b1);
    checkOutput("gap_count", wrCnt, 32'd2);
    checkOutput("gap_addr0", wrAddr[0], 32'h0000_0000);
    checkOutput("gap_data0", wrData[0], 32'h0050_0093);
    checkOutput("gap_addr1", wrAddr[1], 32'h0000_0004);
    checkOutput("gap_data1", wrData[1], 32'h0010_0113);
    checkOutput("gap_loadDone", {31'd0, loadDone}, 32'd1);
    checkOutput("gap_coreHold", {31'd0, coreHold}, 32'd0);
    doReload();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
    $finish;
  end

endmodule
